// File: rtl/addsub_pkg.sv
// Purpose: shared opcode and flag-index constants for the add/subtract pipeline.
// Latency: n/a (constants only).
// Backpressure: n/a.
package addsub_pkg;
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // bit positions inside the registered flag vector
    localparam int FLG_C   = 0;
    localparam int FLG_V   = 1;
    localparam int FLG_Z   = 2;
    localparam int FLG_N   = 3;
    localparam int FLG_NUM = 4;
endpackage

// File: rtl/addsub_pipe_if.sv
// Purpose: operand/result handshake bundle between a producer/consumer and addsub_pipe.
// Latency: n/a (wires only).
// Backpressure: in_valid/in_ready on the operand side, out_valid/out_ready on the result side.
interface addsub_pipe_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic             op;
    logic             signed_mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             ovf;
    logic             zero;
    logic             neg;
    logic             sticky_ovf;
    logic             clr_sticky;

    modport master (
        output in_valid, op, signed_mode, a, b, out_ready, clr_sticky,
        input  in_ready, out_valid, result, carry, ovf, zero, neg, sticky_ovf
    );

    modport slave (
        input  in_valid, op, signed_mode, a, b, out_ready, clr_sticky,
        output in_ready, out_valid, result, carry, ovf, zero, neg, sticky_ovf
    );
endinterface

// File: rtl/addsub_pipe_cla_nbit.sv
// Purpose: N-bit adder, ripple inside GRP-bit groups, lookahead carry across groups.
// Latency: combinational.
// Backpressure: none.
module cla_nbit #(
    parameter int N   = 4,
    parameter int GRP = 4
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic         i_cin,
    output logic [N-1:0] o_sum,
    output logic         o_cout
);
    localparam int NG = N / GRP;

    logic [N-1:0]  w_g;
    logic [N-1:0]  w_p;
    logic [N-1:0]  w_c;
    logic [NG-1:0] w_gg;
    logic [NG-1:0] w_gp;
    logic          w_cy;
    logic          w_bc;

    assign w_g   = i_a & i_b;
    assign w_p   = i_a ^ i_b;
    assign o_sum = w_p ^ w_c;

    // group generate/propagate, built LSB to MSB inside each group
    always_comb begin
        w_gg = '0;
        w_gp = '1;
        for (int k = 0; k < NG; k++) begin
            for (int j = 0; j < GRP; j++) begin
                w_gg[k] = w_g[k*GRP+j] | (w_p[k*GRP+j] & w_gg[k]);
                w_gp[k] = w_gp[k] & w_p[k*GRP+j];
            end
        end
    end

    // group carries chained by lookahead; per-bit carries rippled from each group's carry-in
    always_comb begin
        w_c  = '0;
        w_cy = i_cin;
        w_bc = 1'b0;
        for (int k = 0; k < NG; k++) begin
            w_bc = w_cy;
            for (int j = 0; j < GRP; j++) begin
                w_c[k*GRP+j] = w_bc;
                w_bc         = w_g[k*GRP+j] | (w_p[k*GRP+j] & w_bc);
            end
            w_cy = w_gg[k] | (w_gp[k] & w_cy);
        end
        o_cout = w_cy;
    end
endmodule

// File: rtl/addsub_pipe.sv
// Purpose: 2-stage pipelined add/subtract with carry/overflow/zero/negative flags and sticky overflow.
// Latency: 2 cycles accept-to-out_valid, 1 beat/cycle; ADDSUB_SAT_EN clamps the result on overflow.
// Backpressure: a stalled output holds both stages; in_ready drops only when stage 1 cannot move.
module addsub_pipe
    import addsub_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int CLA_GRP = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    addsub_pipe_if.slave  io_bus
);
    localparam int LO = WIDTH / 2;
    localparam int HI = WIDTH - LO;

    logic               w_s2_adv;
    logic               w_s1_adv;
    logic               w_in_rdy;
    logic               w_acc;
    logic               w_xfer;
    logic [WIDTH-1:0]   w_b_eff;
    logic [LO-1:0]      w_sum_lo;
    logic               w_c_lo;
    logic [HI-1:0]      w_sum_hi;
    logic               w_c_hi;
    logic [WIDTH-1:0]   w_raw;
    logic [WIDTH-1:0]   w_res;
    logic               w_ovf;
    logic [FLG_NUM-1:0] w_flags;

    logic               r_s1_vld;
    logic [HI-1:0]      r_s1_a_hi;
    logic [HI-1:0]      r_s1_b_hi;
    logic               r_s1_op;
    logic               r_s1_sgn;
    logic [LO-1:0]      r_s1_sum_lo;
    logic               r_s1_c_lo;
    logic               r_s2_vld;
    logic [WIDTH-1:0]   r_result;
    logic [FLG_NUM-1:0] r_flags;
    logic               r_sticky;

    assign w_s2_adv = !r_s2_vld || io_bus.out_ready;
    assign w_s1_adv = !r_s1_vld || w_s2_adv;
    assign w_in_rdy = rst_n && w_s1_adv;
    assign w_acc    = io_bus.in_valid && w_in_rdy;
    assign w_xfer   = r_s2_vld && io_bus.out_ready;

    // subtract is a + ~b + 1: invert b and feed op as the carry-in
    assign w_b_eff = (io_bus.op == OP_SUB) ? ~io_bus.b : io_bus.b;

    cla_nbit #(.N(LO), .GRP(CLA_GRP)) u_cla_lo (
        .i_a    (io_bus.a[LO-1:0]),
        .i_b    (w_b_eff[LO-1:0]),
        .i_cin  (io_bus.op == OP_SUB),
        .o_sum  (w_sum_lo),
        .o_cout (w_c_lo)
    );

    cla_nbit #(.N(HI), .GRP(CLA_GRP)) u_cla_hi (
        .i_a    (r_s1_a_hi),
        .i_b    (r_s1_b_hi),
        .i_cin  (r_s1_c_lo),
        .o_sum  (w_sum_hi),
        .o_cout (w_c_hi)
    );

    assign w_raw = {w_sum_hi, r_s1_sum_lo};

    // signed: operands agree in sign but the sum does not; unsigned: carry on add, borrow on sub
    assign w_ovf = r_s1_sgn
                 ? ((r_s1_a_hi[HI-1] == r_s1_b_hi[HI-1]) && (w_sum_hi[HI-1] != r_s1_a_hi[HI-1]))
                 : ((r_s1_op == OP_SUB) ? !w_c_hi : w_c_hi);

`ifdef ADDSUB_SAT_EN
    // clamp toward the side the true result overflowed to
    always_comb begin
        w_res = w_raw;
        if (w_ovf) begin
            if (r_s1_sgn) begin
                w_res = r_s1_a_hi[HI-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
            end else if (r_s1_op == OP_SUB) begin
                w_res = '0;
            end else begin
                w_res = '1;
            end
        end
    end
`else
    assign w_res = w_raw;
`endif

    // zero/neg come from the final (possibly clamped) result, carry/ovf from the raw add
    always_comb begin
        w_flags        = '0;
        w_flags[FLG_C] = w_c_hi;
        w_flags[FLG_V] = w_ovf;
        w_flags[FLG_Z] = (w_res == '0);
        w_flags[FLG_N] = w_res[WIDTH-1];
    end

    // stage 1 valid moves whenever the stage can advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_vld <= 1'b0;
        end else if (w_s1_adv) begin
            r_s1_vld <= io_bus.in_valid;
        end
    end

    // stage 1 data loads only on an accepted beat so idle-cycle X never enters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_a_hi   <= '0;
            r_s1_b_hi   <= '0;
            r_s1_op     <= 1'b0;
            r_s1_sgn    <= 1'b0;
            r_s1_sum_lo <= '0;
            r_s1_c_lo   <= 1'b0;
        end else if (w_acc) begin
            r_s1_a_hi   <= io_bus.a[WIDTH-1:LO];
            r_s1_b_hi   <= w_b_eff[WIDTH-1:LO];
            r_s1_op     <= io_bus.op;
            r_s1_sgn    <= io_bus.signed_mode;
            r_s1_sum_lo <= w_sum_lo;
            r_s1_c_lo   <= w_c_lo;
        end
    end

    // stage 2 valid and result/flags; data only replaced by a real stage-1 beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_vld <= 1'b0;
            r_result <= '0;
            r_flags  <= '0;
        end else if (w_s2_adv) begin
            r_s2_vld <= r_s1_vld;
            if (r_s1_vld) begin
                r_result <= w_res;
                r_flags  <= w_flags;
            end
        end
    end

    // sticky overflow: a transferring ovf beat beats a same-cycle clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sticky <= 1'b0;
        end else if (w_xfer && r_flags[FLG_V]) begin
            r_sticky <= 1'b1;
        end else if (io_bus.clr_sticky) begin
            r_sticky <= 1'b0;
        end
    end

    assign io_bus.in_ready   = w_in_rdy;
    assign io_bus.out_valid  = r_s2_vld;
    assign io_bus.result     = r_result;
    assign io_bus.carry      = r_flags[FLG_C];
    assign io_bus.ovf        = r_flags[FLG_V];
    assign io_bus.zero       = r_flags[FLG_Z];
    assign io_bus.neg        = r_flags[FLG_N];
    assign io_bus.sticky_ovf = r_sticky;
endmodule
